// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative RV-M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  a_i;
  logic [XLEN-1:0]  b_i;
  logic [TAG_W-1:0] tag_i;
  logic             kill;
  logic             busy_o;
  logic             valid_o;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output valid_i, op_i, a_i, b_i, tag_i, kill,
    input  ready_o, busy_o, valid_o, result_o, tag_o
  );

  modport slave (
    input  valid_i, op_i, a_i, b_i, tag_i, kill,
    output ready_o, busy_o, valid_o, result_o, tag_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV-M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with a sign fix-up cycle and a one-cycle result pulse.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TAG_W-1:0]   rtag_q, rtag_d;
  logic               neg_q, neg_d;
  logic [XLEN-1:0]    opnd_q, opnd_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [2*XLEN-1:0]  acc_q, acc_d;

  logic               is_div, a_sgn, b_sgn, a_neg, b_neg, div0, ovf, accept;
  logic [XLEN-1:0]    a_mag, b_mag, early_res;
  logic [XLEN:0]      mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]  prod;
  logic [XLEN-1:0]    quot, rem, fix_res;

  // Request decode: which operands are signed, their magnitudes, and the early-out cases.
  always_comb begin
    is_div    = bus.op_i[2];
    a_sgn     = is_div ? ~bus.op_i[0] : (bus.op_i[1:0] != 2'b11);
    b_sgn     = is_div ? ~bus.op_i[0] : ~bus.op_i[1];
    a_neg     = a_sgn & bus.a_i[XLEN-1];
    b_neg     = b_sgn & bus.b_i[XLEN-1];
    a_mag     = a_neg ? -bus.a_i : bus.a_i;
    b_mag     = b_neg ? -bus.b_i : bus.b_i;
    div0      = is_div && (bus.b_i == '0);
    ovf       = is_div && ~bus.op_i[0] && (bus.a_i == MIN_VAL) && (bus.b_i == '1);
    if (div0) begin
      early_res = bus.op_i[1] ? bus.a_i : '1;
    end else begin
      early_res = bus.op_i[1] ? '0 : MIN_VAL;
    end
    accept    = bus.valid_i && (state_q == S_IDLE) && !bus.kill;
  end

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    prod      = neg_q ? -acc_q : acc_q;
    quot      = acc_q[XLEN-1:0];
    rem       = acc_q[2*XLEN-1:XLEN];
    if (!op_q[2]) begin
      fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (!op_q[1]) begin
      fix_res = neg_q ? -quot : quot;
    end else begin
      fix_res = neg_q ? -rem : rem;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    tag_d    = tag_q;
    rtag_d   = rtag_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    acc_d    = acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = bus.op_i;
          tag_d = bus.tag_i;
          if (div0 || ovf) begin
            result_d = early_res;
            rtag_d   = bus.tag_i;
            state_d  = S_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN - 1);
            opnd_d  = is_div ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            neg_d   = (is_div && bus.op_i[1]) ? a_neg : (a_neg ^ b_neg);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!op_q[2]) begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end else if (div_diff[XLEN]) begin
          acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
        if (cnt_q == '0) begin
          state_d = S_FIXUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIXUP: begin
        result_d = fix_res;
        rtag_d   = tag_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flush drops the op; the visible result and tag stay as they were.
    if (bus.kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
      rtag_d   = rtag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      rtag_q   <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      result_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      rtag_q   <= rtag_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.ready_o  = (state_q == S_IDLE);
  assign bus.busy_o   = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign bus.valid_o  = (state_q == S_DONE);
  assign bus.result_o = result_q;
  assign bus.tag_o    = rtag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at XLEN=32 and XLEN=16 against an arithmetic reference model.
module tb_muldiv_unit;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32), .TAG_W(5)) b32 ();
  muldiv_unit_if #(.XLEN(16), .TAG_W(5)) b16 ();

  muldiv_unit #(.XLEN(32), .TAG_W(5)) u32 (.clk(clk), .reset(reset), .bus(b32));
  muldiv_unit #(.XLEN(16), .TAG_W(5)) u16 (.clk(clk), .reset(reset), .bus(b16));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  bit          pending [2];
  int          exp_cyc [2];
  logic [31:0] exp_res [2];
  logic [4:0]  exp_tag [2];
  logic [31:0] m_res   [2];
  logic [4:0]  m_tag   [2];
  int          last_v  [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (dut%0d, cycle %0d): got %h, expected %h", name, d, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a_in,
                                       input logic [31:0] b_in, input int w);
    logic [31:0] mask, minv, a, b, r;
    logic signed [127:0] ua, ub, sa, sb, p;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    minv = 32'd1 << (w - 1);
    a = a_in & mask;
    b = b_in & mask;
    ua = $signed({96'd0, a});
    ub = $signed({96'd0, b});
    sa = ua;
    sb = ub;
    if (a[w-1]) sa = ua - (128'sd1 <<< w);
    if (b[w-1]) sb = ub - (128'sd1 <<< w);
    r = '0;
    case (op)
      MUL:    begin p = sa * sb; r = p[31:0]; end
      MULH:   begin p = sa * sb; p = p >>> w; r = p[31:0]; end
      MULHSU: begin p = sa * ub; p = p >>> w; r = p[31:0]; end
      MULHU:  begin p = ua * ub; p = p >>> w; r = p[31:0]; end
      DIV: begin
        if (b == 0) r = '1;
        else if (a == minv && b == mask) r = minv;
        else begin p = sa / sb; r = p[31:0]; end
      end
      DIVU: begin
        if (b == 0) r = '1;
        else begin p = ua / ub; r = p[31:0]; end
      end
      REM: begin
        if (b == 0) r = a;
        else if (a == minv && b == mask) r = '0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r & mask;
  endfunction

  function automatic bit is_early(input logic [2:0] op, input logic [31:0] a_in,
                                  input logic [31:0] b_in, input int w);
    logic [31:0] mask, minv;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    minv = 32'd1 << (w - 1);
    return op[2] && (((b_in & mask) == 0) ||
                     (!op[0] && (a_in & mask) == minv && (b_in & mask) == mask));
  endfunction

  function automatic logic [31:0] res_of(input int d);
    return (d == 0) ? b32.result_o : {16'h0, b16.result_o};
  endfunction
  function automatic logic [31:0] tag_of(input int d);
    return (d == 0) ? {27'h0, b32.tag_o} : {27'h0, b16.tag_o};
  endfunction
  function automatic logic [31:0] flags_of(input int d);
    // {valid_o, busy_o, ready_o}
    return (d == 0) ? {29'h0, b32.valid_o, b32.busy_o, b32.ready_o}
                    : {29'h0, b16.valid_o, b16.busy_o, b16.ready_o};
  endfunction

  // Single compare process: cycle-by-cycle expectations from the scoreboard.
  bit vexp;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        if (pending[d] && cyc > exp_cyc[d]) begin
          n_checks++;
          n_errors++;
          $display("FAIL no_result (dut%0d, cycle %0d): got no valid_o, expected it at cycle %0d", d, cyc, exp_cyc[d]);
          pending[d] = 0;
        end
        vexp = pending[d] && (cyc == exp_cyc[d]);
        check("valid_o", d, {31'h0, flags_of(d)[2]}, {31'h0, vexp});
        check("busy_o",  d, {31'h0, flags_of(d)[1]}, {31'h0, pending[d] && !vexp});
        check("ready_o", d, {31'h0, flags_of(d)[0]}, {31'h0, !pending[d]});
        if (vexp) begin
          m_res[d]   = exp_res[d];
          m_tag[d]   = exp_tag[d];
          pending[d] = 0;
        end
        check("result_o", d, res_of(d), m_res[d]);
        check("tag_o",    d, tag_of(d), {27'h0, m_tag[d]});
      end
    end
  end

  always @(negedge clk) begin
    if (b32.valid_o === 1'b1) last_v[0] = cyc;
    if (b16.valid_o === 1'b1) last_v[1] = cyc;
  end

  task automatic drive(input int d, input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input logic k);
    if (d == 0) begin
      b32.valid_i = v; b32.op_i = op; b32.a_i = a; b32.b_i = b; b32.tag_i = tag; b32.kill = k;
    end else begin
      b16.valid_i = v; b16.op_i = op; b16.a_i = a[15:0]; b16.b_i = b[15:0]; b16.tag_i = tag; b16.kill = k;
    end
  endtask

  task automatic start_op(input int d, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, output int n);
    int w;
    w = (d == 0) ? 32 : 16;
    @(posedge clk); #1;
    drive(d, 1'b1, op, a, b, tag, 1'b0);
    n = cyc;
    @(posedge clk); #1;
    // Scramble the operands after accept; the unit must have latched them.
    drive(d, 1'b0, ~op, ~a, b ^ 32'h5A5A_A5A5, ~tag, 1'b0);
    exp_res[d] = model(op, a, b, w);
    exp_tag[d] = tag;
    exp_cyc[d] = n + (is_early(op, a, b, w) ? 1 : w + 2);
    pending[d] = 1;
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 100 && pending[d]; i++) begin
      @(negedge clk); #1;
    end
    if (pending[d]) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_done (dut%0d): got no result, expected one within 100 cycles", d);
      pending[d] = 0;
    end
  endtask

  task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] lit, output int n);
    start_op(d, op, a, b, tag, n);
    wait_done(d);
    check("lit_result", d, res_of(d), lit);
    check("lit_tag", d, tag_of(d), {27'h0, tag});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  int n;
  initial begin
    for (int d = 0; d < 2; d++) begin
      pending[d] = 0; m_res[d] = '0; m_tag[d] = '0; exp_cyc[d] = 0; last_v[d] = -1;
      drive(d, 1'b0, 3'd0, '0, '0, '0, 1'b0);
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1;
    @(negedge clk); #1;
    check("reset_flags",  0, flags_of(0), 32'h1);
    check("reset_result", 0, res_of(0), 32'h0);
    check("reset_tag",    0, tag_of(0), 32'h0);

    // Multiply
    run_op(0, MUL, 32'h7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, n);
    check("latency_mul32", 0, 32'(last_v[0] - n), 32'd34);
    run_op(0, MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, n);
    run_op(0, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, n);
    run_op(0, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, n);
    run_op(0, MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001, n);
    run_op(0, MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000, n);
    run_op(0, MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7, 32'hFFFF_FFFF, n);

    // Divide
    run_op(0, DIV,  32'hFFFF_FFF9, 32'h2, 5'd8,  32'hFFFF_FFFD, n);
    run_op(0, REM,  32'hFFFF_FFF9, 32'h2, 5'd9,  32'hFFFF_FFFF, n);
    run_op(0, DIVU, 32'hFFFF_FFFF, 32'h2, 5'd10, 32'h7FFF_FFFF, n);
    run_op(0, DIV,  32'h7, 32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, n);
    run_op(0, REM,  32'h7, 32'hFFFF_FFFE, 5'd12, 32'h0000_0001, n);
    run_op(0, REMU, 32'd100, 32'd7, 5'd13, 32'd2, n);
    run_op(0, DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0, n);

    // Early-out cases
    run_op(0, DIV, 32'd5, 32'd0, 5'd15, 32'hFFFF_FFFF, n);
    check("latency_div0", 0, 32'(last_v[0] - n), 32'd1);
    run_op(0, REM, 32'd5, 32'd0, 5'd16, 32'd5, n);
    run_op(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, n);
    check("latency_ovf", 0, 32'(last_v[0] - n), 32'd1);
    run_op(0, REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0, n);
    run_op(0, REMU, 32'd9, 32'd0, 5'd19, 32'd9, n);

    // kill in DONE with a simultaneous request: the result stays visible, nothing is accepted
    start_op(0, DIV, 32'd5, 32'd0, 5'd3, n);
    drive(0, 1'b1, MUL, 32'd2, 32'd3, 5'd4, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'd0, '0, '0, '0, 1'b0);
    @(negedge clk); #1;
    check("kill_done_flags",  0, flags_of(0), 32'h1);
    check("kill_done_result", 0, res_of(0), 32'hFFFF_FFFF);
    repeat (40) @(posedge clk);

    // kill on CALC cycle 10
    start_op(0, MUL, 32'd123, 32'd456, 5'd20, n);
    repeat (9) @(posedge clk);
    #1 drive(0, 1'b0, 3'd0, '0, '0, '0, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'd0, '0, '0, '0, 1'b0);
    pending[0] = 0;
    @(negedge clk); #1;
    check("kill_calc_flags",  0, flags_of(0), 32'h1);
    check("kill_calc_result", 0, res_of(0), 32'hFFFF_FFFF);
    check("kill_calc_tag",    0, tag_of(0), 32'd3);
    repeat (40) @(posedge clk);
    run_op(0, MULHU, 32'd3, 32'd5, 5'd21, 32'd0, n);

    // kill together with valid_i in IDLE: no accept
    @(posedge clk); #1;
    drive(0, 1'b1, MUL, 32'd3, 32'd3, 5'd1, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'd0, '0, '0, '0, 1'b0);
    @(negedge clk); #1;
    check("kill_idle_flags", 0, flags_of(0), 32'h1);
    repeat (40) @(posedge clk);

    // reset in the middle of a divide
    start_op(0, DIV, 32'd100, 32'd7, 5'd2, n);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pending[d] = 0; m_res[d] = '0; m_tag[d] = '0;
    end
    @(negedge clk); #1;
    check("midreset_flags",  0, flags_of(0), 32'h1);
    check("midreset_result", 0, res_of(0), 32'h0);
    check("midreset_tag",    0, tag_of(0), 32'h0);
    repeat (40) @(posedge clk);

    // XLEN=16 instance
    run_op(1, MUL, 32'h7, 32'hFFFD, 5'd5, 32'hFFEB, n);
    check("latency_mul16", 1, 32'(last_v[1] - n), 32'd18);
    run_op(1, DIV,   32'h8000, 32'hFFFF, 5'd6, 32'h8000, n);
    run_op(1, REM,   32'hFFF9, 32'h0002, 5'd7, 32'hFFFF, n);
    run_op(1, MULHU, 32'hFFFF, 32'hFFFF, 5'd8, 32'hFFFE, n);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
